// File: rtl/x2050rtn_if.sv
// Signal bundle between the routine-request scheduler and the channel/ROS side.
// The slave modport is the scheduler's view; the master modport is the driver's view.
interface x2050rtn_if #(
  parameter int NREQ = 4
);
  logic            i_ros_advance;
  logic            i_break_ok;
  logic [NREQ-1:0] i_req;
  logic            i_routine_end;
  logic [NREQ-1:0] o_routine_requesting;
  logic            o_routine_recd;
  logic            o_firstcycle;
  logic            o_busy;
  logic            o_timeout;
  logic [1:0]      o_state;

  modport slave (
    input  i_ros_advance, i_break_ok, i_req, i_routine_end,
    output o_routine_requesting, o_routine_recd, o_firstcycle,
           o_busy, o_timeout, o_state
  );

  modport master (
    output i_ros_advance, i_break_ok, i_req, i_routine_end,
    input  o_routine_requesting, o_routine_recd, o_firstcycle,
           o_busy, o_timeout, o_state
  );
endinterface

// File: rtl/x2050rtn.sv
// Routine-request scheduler: fixed-priority arbitration with a one-deep fairness
// mask, ROS break-in sequencing and a ROS-advance timeout on the running routine.
module x2050rtn #(
  parameter int NREQ     = 4,
  parameter int TOUT_W   = 8,
  parameter int TOUT_MAX = 200
) (
  input  logic          i_clk,
  input  logic          i_reset,
  x2050rtn_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_FIRST  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_MAX - 1);
  localparam logic [TOUT_W-1:0] TOUT_SAT  = '1;

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_mask;
  logic [TOUT_W-1:0] r_timer;
  logic              r_timeout;

  logic [NREQ-1:0]   w_masked;
  logic [NREQ-1:0]   w_eff;
  logic [NREQ-1:0]   w_winner;
  logic              w_withdraw;
  logic              w_recd;
  logic              w_first;

  // The last-served channel steps aside only if someone else is asking.
  assign w_masked   = bus.i_req & ~r_mask;
  assign w_eff      = (|w_masked) ? w_masked : bus.i_req;
  assign w_winner   = w_eff & (~w_eff + NREQ'(1));

  assign w_withdraw = ~|(bus.i_req & r_grant);
  assign w_recd     = (r_state == ST_PEND) & ~w_withdraw
                      & bus.i_ros_advance & bus.i_break_ok;
  assign w_first    = (r_state == ST_FIRST) & bus.i_ros_advance;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_mask    <= '0;
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|bus.i_req) begin
            r_grant <= w_winner;
            r_state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_withdraw) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if (bus.i_ros_advance && bus.i_break_ok) begin
            r_state <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (bus.i_ros_advance) begin
            r_timer <= '0;
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // Routine end takes precedence over an overrun on the same advance.
          if (bus.i_ros_advance) begin
            if (bus.i_routine_end) begin
              r_mask  <= r_grant;
              r_grant <= '0;
              r_state <= ST_IDLE;
            end else if (r_timer == TOUT_LAST) begin
              r_mask    <= r_grant;
              r_grant   <= '0;
              r_timeout <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (r_timer != TOUT_SAT) begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_routine_requesting = r_grant;
  assign bus.o_routine_recd       = w_recd;
  assign bus.o_firstcycle         = w_first;
  assign bus.o_busy               = (r_state != ST_IDLE);
  assign bus.o_timeout            = r_timeout;
  assign bus.o_state              = r_state;

endmodule

// File: tb/tb_x2050rtn.sv
// Directed-vector bench for x2050rtn (TOUT_MAX=3): timing, fairness, withdrawal,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_x2050rtn;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  x2050rtn_if #(.NREQ(4)) bus ();

  x2050rtn #(.NREQ(4), .TOUT_W(8), .TOUT_MAX(3)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE with requests, advance and break_ok held: serve one short routine.
  task automatic serve(input string tag, input logic [3:0] exp_grant);
    step();
    check_eq({tag, ".grant"}, 32'(bus.o_routine_requesting), 32'(exp_grant));
    check_eq({tag, ".recd"}, 32'(bus.o_routine_recd), 1);
    step();
    check_eq({tag, ".first"}, 32'(bus.o_firstcycle), 1);
    step();
    check_eq({tag, ".active"}, 32'(bus.o_state), 3);
    bus.i_routine_end = 1'b1;
    step();
    bus.i_routine_end = 1'b0;
    check_eq({tag, ".idle"}, 32'(bus.o_busy), 0);
    $display("serve %s: requesting=%b", tag, exp_grant);
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_req         = '0;
    bus.i_ros_advance = 1'b0;
    bus.i_break_ok    = 1'b0;
    bus.i_routine_end = 1'b0;
    repeat (2) step();
    check_eq("rst.state", 32'(bus.o_state), 0);
    check_eq("rst.busy", 32'(bus.o_busy), 0);
    check_eq("rst.grant", 32'(bus.o_routine_requesting), 0);
    check_eq("rst.tout", 32'(bus.o_timeout), 0);
    rst = 1'b0;

    // Single request, latency check; end lands on the would-be timeout advance.
    bus.i_req = 4'b0010; bus.i_ros_advance = 1'b1; bus.i_break_ok = 1'b1;
    step();
    check_eq("single.grant", 32'(bus.o_routine_requesting), 32'h2);
    check_eq("single.pend", 32'(bus.o_state), 1);
    check_eq("single.recd", 32'(bus.o_routine_recd), 1);
    check_eq("single.nofirst", 32'(bus.o_firstcycle), 0);
    step();
    check_eq("single.firstst", 32'(bus.o_state), 2);
    check_eq("single.first", 32'(bus.o_firstcycle), 1);
    check_eq("single.norecd", 32'(bus.o_routine_recd), 0);
    step();
    check_eq("single.active", 32'(bus.o_state), 3);
    step();
    step();
    check_eq("single.active2", 32'(bus.o_state), 3);
    bus.i_routine_end = 1'b1; bus.i_req = '0;
    step();
    bus.i_routine_end = 1'b0;
    check_eq("single.busy", 32'(bus.o_busy), 0);
    check_eq("single.granted0", 32'(bus.o_routine_requesting), 0);
    check_eq("single.endwins", 32'(bus.o_timeout), 0);
    step();
    check_eq("single.endwins2", 32'(bus.o_timeout), 0);
    $display("single: requesting=0010 served");

    // Fairness: mask=0010 from the previous routine.
    bus.i_req = 4'b0011;
    serve("fair1", 4'b0001);
    serve("fair2", 4'b0010);
    serve("fair3", 4'b0001);

    // Sole requester served back-to-back.
    bus.i_req = 4'b0100;
    serve("sole1", 4'b0100);
    serve("sole2", 4'b0100);
    bus.i_req = '0;

    // Withdrawal before break-in; mask must stay 0100.
    bus.i_ros_advance = 1'b0; bus.i_break_ok = 1'b0;
    bus.i_req = 4'b1000;
    step();
    check_eq("wd.grant", 32'(bus.o_routine_requesting), 32'h8);
    check_eq("wd.pend", 32'(bus.o_state), 1);
    step();
    check_eq("wd.wait", 32'(bus.o_state), 1);
    bus.i_req = '0; bus.i_ros_advance = 1'b1; bus.i_break_ok = 1'b1;
    #1;
    check_eq("wd.norecd", 32'(bus.o_routine_recd), 0);
    step();
    check_eq("wd.idle", 32'(bus.o_state), 0);
    check_eq("wd.grant0", 32'(bus.o_routine_requesting), 0);
    bus.i_ros_advance = 1'b0; bus.i_break_ok = 1'b0;
    bus.i_req = 4'b1100;
    step();
    check_eq("wd.maskkept", 32'(bus.o_routine_requesting), 32'h8);
    bus.i_req = '0;
    step();
    check_eq("wd.idle2", 32'(bus.o_state), 0);
    $display("withdraw: requesting=1000 dropped");

    // Timeout after the third ACTIVE advance.
    bus.i_req = 4'b0001; bus.i_ros_advance = 1'b1; bus.i_break_ok = 1'b1;
    step(); step(); step();
    check_eq("to.active", 32'(bus.o_state), 3);
    bus.i_ros_advance = 1'b0; bus.i_routine_end = 1'b1;
    step();
    check_eq("to.endnoadv", 32'(bus.o_state), 3);
    bus.i_ros_advance = 1'b1; bus.i_routine_end = 1'b0;
    step(); step();
    check_eq("to.still", 32'(bus.o_state), 3);
    check_eq("to.early", 32'(bus.o_timeout), 0);
    bus.i_req = '0;
    step();
    check_eq("to.pulse", 32'(bus.o_timeout), 1);
    check_eq("to.idle", 32'(bus.o_state), 0);
    check_eq("to.grant0", 32'(bus.o_routine_requesting), 0);
    step();
    check_eq("to.single", 32'(bus.o_timeout), 0);
    $display("timeout: requesting=0001 overran");

    // Asynchronous reset between clocks while ACTIVE; mask must clear.
    bus.i_req = 4'b0010;
    step(); step(); step();
    check_eq("ar.active", 32'(bus.o_state), 3);
    #2 rst = 1'b1;
    #1;
    check_eq("ar.state", 32'(bus.o_state), 0);
    check_eq("ar.busy", 32'(bus.o_busy), 0);
    check_eq("ar.grant", 32'(bus.o_routine_requesting), 0);
    check_eq("ar.recd", 32'(bus.o_routine_recd), 0);
    check_eq("ar.first", 32'(bus.o_firstcycle), 0);
    check_eq("ar.tout", 32'(bus.o_timeout), 0);
    step();
    rst = 1'b0;
    bus.i_req = 4'b0011;
    step();
    check_eq("ar.rearb", 32'(bus.o_routine_requesting), 32'h1);
    check_eq("ar.recd2", 32'(bus.o_routine_recd), 1);
    $display("areset: requesting=0001 after release");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
